data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_ctrl
// Brief    : Data memory with byte/half/word access, configurable latency and
//            valid/ready handshakes on request and response.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  count;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [31:0] memory [DEPTH];

    logic          op_we;
    logic [1:0]    op_size;
    logic          op_unsigned;
    logic [31:0]   op_addr;
    logic [31:0]   op_wdata;
    logic          enter_resp;
    logic          op_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [3:0]    lane_en;
    logic [31:0]   wr_data;
    logic          mem_we;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // With LATENCY==1 the access completes on the acceptance edge, so the
    // live request fields are used before they have been latched.
    always_comb begin
        if (state == IDLE) begin
            op_we       = req_we;
            op_size     = req_size;
            op_unsigned = req_unsigned;
            op_addr     = req_addr;
            op_wdata    = req_wdata;
        end else begin
            op_we       = lat_we;
            op_size     = lat_size;
            op_unsigned = lat_unsigned;
            op_addr     = lat_addr;
            op_wdata    = lat_wdata;
        end
    end

    assign enter_resp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                        ((state == WAIT) && (count == 4'd1));

    assign word_idx = op_addr[AW+1:2];
    assign op_err   = (op_size == 2'b11) ||
                      ((op_size == 2'b01) && op_addr[0]) ||
                      ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) ||
                      (|op_addr[31:AW+2]);

    assign rd_word  = memory[word_idx];
    assign byte_sel = rd_word[{op_addr[1:0], 3'b000} +: 8];
    assign half_sel = op_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        lane_en   = 4'b1111;
        wr_data   = op_wdata;
        case (op_size)
            2'b00: begin
                load_data = {{24{byte_sel[7] & ~op_unsigned}}, byte_sel};
                lane_en   = 4'b0001 << op_addr[1:0];
                wr_data   = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                load_data = {{16{half_sel[15] & ~op_unsigned}}, half_sel};
                lane_en   = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign mem_we = enter_resp && op_we && !op_err && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    memory[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= 4'd0;
            lat_we       <= 1'b0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we       <= req_we;
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                            count <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Response entry overrides the per-state updates above.
            if (enter_resp) begin
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= op_err;
                rsp_rdata <= (op_err || op_we) ? 32'd0 : load_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_ctrl
// Brief    : Directed self-checking bench; one controller at LATENCY=1 and one
//            at LATENCY=4 share the request fields but have separate valids.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst1, rst4;
    logic        valid1, valid4;
    logic        req_ready1, req_ready4;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid1, rsp_valid4;
    logic        rdy1, rdy4;
    logic [31:0] rsp_rdata1, rsp_rdata4;
    logic        rsp_err1, rsp_err4;
    logic        busy1, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(valid1), .req_ready(req_ready1),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
        .rsp_ready(rdy1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
    );

    data_mem_ctrl #(.DEPTH(256), .LATENCY(4)) dut4 (
        .clk(clk), .reset(rst4), .req_valid(valid4), .req_ready(req_ready4),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid4),
        .rsp_ready(rdy4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction on the selected controller (sel=1 -> LATENCY 4).
    task automatic xfer(input string tag, input bit sel, input bit we, input logic [1:0] size,
                        input bit uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        int lat;
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        rdy1 = 1'b1; rdy4 = 1'b1;
        n = 0;
        while (!(sel ? req_ready4 : req_ready1) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (sel) valid4 = 1'b1; else valid1 = 1'b1;
        @(posedge clk); #1;
        valid1 = 1'b0; valid4 = 1'b0;
        lat = 1;
        while (!(sel ? rsp_valid4 : rsp_valid1) && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"}, lat, sel ? 4 : 1);
        check({tag, "_rdata"}, sel ? rsp_rdata4 : rsp_rdata1, exp_rdata);
        check({tag, "_err"}, {31'd0, sel ? rsp_err4 : rsp_err1}, {31'd0, exp_err});
        @(posedge clk); #1;
        check({tag, "_ready_after"}, {31'd0, sel ? req_ready4 : req_ready1}, 32'd1);
        check({tag, "_valid_after"}, {31'd0, sel ? rsp_valid4 : rsp_valid1}, 32'd0);
    endtask

    initial begin
        int n;
        rst1 = 1'b1; rst4 = 1'b1;
        valid1 = 1'b0; valid4 = 1'b0; rdy1 = 1'b1; rdy4 = 1'b1;
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clk); #1;
        check("rst_ready1", {31'd0, req_ready1}, 32'd1);
        check("rst_valid1", {31'd0, rsp_valid1}, 32'd0);
        check("rst_rdata1", rsp_rdata1, 32'd0);
        check("rst_err1",   {31'd0, rsp_err1}, 32'd0);
        check("rst_busy1",  {31'd0, busy1}, 32'd0);
        check("rst_busy4",  {31'd0, busy4}, 32'd0);
        @(posedge clk); #1;
        rst1 = 1'b0; rst4 = 1'b0;
        @(posedge clk); #1;

        // Preload through stores
        xfer("sw_pre2", 0, 1, 2'b10, 0, 32'h8, 32'h0000_0014, 32'd0, 1'b0);
        xfer("sw_pre1", 0, 1, 2'b10, 0, 32'h4, 32'h8081_F0FE, 32'd0, 1'b0);
        xfer("sw_pre3", 0, 1, 2'b10, 0, 32'hC, 32'h1122_3344, 32'd0, 1'b0);

        xfer("lw_8",   0, 0, 2'b10, 0, 32'h8, 32'd0, 32'h0000_0014, 1'b0);
        xfer("lb_4",   0, 0, 2'b00, 0, 32'h4, 32'd0, 32'hFFFF_FFFE, 1'b0);
        xfer("lbu_4",  0, 0, 2'b00, 1, 32'h4, 32'd0, 32'h0000_00FE, 1'b0);
        xfer("lh_6",   0, 0, 2'b01, 0, 32'h6, 32'd0, 32'hFFFF_8081, 1'b0);
        xfer("lhu_6",  0, 0, 2'b01, 1, 32'h6, 32'd0, 32'h0000_8081, 1'b0);
        xfer("lbu_5",  0, 0, 2'b00, 1, 32'h5, 32'd0, 32'h0000_00F0, 1'b0);

        xfer("sb_D",   0, 1, 2'b00, 0, 32'hD, 32'h0000_00AA, 32'd0, 1'b0);
        xfer("lw_C1",  0, 0, 2'b10, 0, 32'hC, 32'd0, 32'h1122_AA44, 1'b0);
        xfer("sh_E",   0, 1, 2'b01, 0, 32'hE, 32'h0000_BEEF, 32'd0, 1'b0);
        xfer("lw_C2",  0, 0, 2'b10, 0, 32'hC, 32'd0, 32'hBEEF_AA44, 1'b0);

        xfer("lw_mis", 0, 0, 2'b10, 0, 32'h6, 32'd0, 32'd0, 1'b1);
        xfer("sh_mis", 0, 1, 2'b01, 0, 32'h5, 32'h0000_5555, 32'd0, 1'b1);
        xfer("lw_4",   0, 0, 2'b10, 0, 32'h4, 32'd0, 32'h8081_F0FE, 1'b0);
        xfer("lw_oor", 0, 0, 2'b10, 0, 32'h400, 32'd0, 32'd0, 1'b1);
        xfer("sz_ill", 0, 0, 2'b11, 0, 32'h0, 32'd0, 32'd0, 1'b1);

        // LATENCY=4 controller
        xfer("sw4_0",  1, 1, 2'b10, 0, 32'h0,  32'h1234_5678, 32'd0, 1'b0);
        xfer("sw4_4",  1, 1, 2'b10, 0, 32'h4,  32'hCAFE_F00D, 32'd0, 1'b0);
        xfer("sw4_10", 1, 1, 2'b10, 0, 32'h10, 32'h0BAD_F00D, 32'd0, 1'b0);

        // Stalled response with a second request held throughout
        req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'd0; rdy4 = 1'b0; valid4 = 1'b1;
        @(posedge clk); #1;
        check("st_busy_acc",  {31'd0, busy4}, 32'd1);
        check("st_ready_acc", {31'd0, req_ready4}, 32'd0);
        req_addr = 32'h4;
        for (int i = 1; i <= 2; i++) begin
            @(posedge clk); #1;
            check("st_valid_early", {31'd0, rsp_valid4}, 32'd0);
            check("st_busy_wait",   {31'd0, busy4}, 32'd1);
        end
        @(posedge clk); #1;
        check("st_valid_rise", {31'd0, rsp_valid4}, 32'd1);
        check("st_rdata_rise", rsp_rdata4, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("st_valid_hold", {31'd0, rsp_valid4}, 32'd1);
            check("st_rdata_hold", rsp_rdata4, 32'h1234_5678);
            check("st_busy_hold",  {31'd0, busy4}, 32'd1);
            check("st_ready_hold", {31'd0, req_ready4}, 32'd0);
        end
        rdy4 = 1'b1;
        @(posedge clk); #1;
        check("st_valid_hs", {31'd0, rsp_valid4}, 32'd0);
        check("st_ready_hs", {31'd0, req_ready4}, 32'd1);
        @(posedge clk); #1;
        check("st2_busy_acc", {31'd0, busy4}, 32'd1);
        valid4 = 1'b0;
        n = 1;
        while (!rsp_valid4 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check("st2_lat",   n, 4);
        check("st2_rdata", rsp_rdata4, 32'hCAFE_F00D);
        @(posedge clk); #1;

        // Reset while a store waits in WAIT: the store must be dropped
        req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10;
        req_wdata = 32'hDEAD_BEEF; valid4 = 1'b1;
        @(posedge clk); #1;
        valid4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b1;
        #1;
        check("rr_valid", {31'd0, rsp_valid4}, 32'd0);
        check("rr_busy",  {31'd0, busy4}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        #1;
        check("rr_ready", {31'd0, req_ready4}, 32'd1);
        xfer("rr_lw10", 1, 0, 2'b10, 0, 32'h10, 32'd0, 32'h0BAD_F00D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
